// File: rtl/shift_pkg.sv
// Shared definitions for the sequential right shifter: FSM states and sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

   localparam int WIDTH      = 32;
   localparam int SHAMT_W    = 5;
   localparam int NUM_STAGES = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/right_shift_stage.sv
// One binary-weighted step of a barrel shift: data >> (16 >> stage), vacated MSBs get fill.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module right_shift_stage #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] data,
   input  logic [2:0]       stage,
   input  logic             enable,
   input  logic             fill,
   output logic [WIDTH-1:0] result
);
   import shift_pkg::*;

   logic [4:0] amt;

   // Pick this stage's weight, then shift a fill-extended copy so the top bits come from fill.
   always_comb begin
      amt = 5'd0;
      if (stage < 3'(NUM_STAGES)) begin
         amt = 5'd16 >> stage;
      end
      result = data;
      if (enable) begin
         result = WIDTH'({{WIDTH{fill}}, data} >> amt);
      end
   end

endmodule

// File: rtl/seq_right_shifter.sv
// Sequential 32-bit logical/arithmetic right shifter, one barrel stage per cycle.
// Latency: result valid on the 5th edge after the accepting edge, independent of shift amount.
// Backpressure: result held in DONE until out_ready; no new request taken until back in IDLE.
module seq_right_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic               in_arith,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data
);
   import shift_pkg::*;

   localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

   state_t             state;
   logic [2:0]         cnt;
   logic [WIDTH-1:0]   work;
   logic [SHAMT_W-1:0] shamt_q;
   // in_arith only matters through the fill bit, so it is folded into fill at capture.
   logic               fill_q;
   logic [2:0]         bit_idx;
   logic               stage_en;
   logic [WIDTH-1:0]   stage_out;

   // Handshake flags decode straight from the state; result comes from the working register.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      out_data  = work;
   end

   // Stage k consumes shamt bit 4-k, so the biggest shift is applied first.
   always_comb begin
      bit_idx  = LAST_STAGE - cnt;
      stage_en = 1'b0;
      if ((state == SHIFT) && (cnt <= LAST_STAGE)) begin
         stage_en = shamt_q[bit_idx];
      end
   end

   right_shift_stage #(
      .WIDTH (WIDTH)
   ) u_stage (
      .data   (work),
      .stage  (cnt),
      .enable (stage_en),
      .fill   (fill_q),
      .result (stage_out)
   );

   // Control FSM and datapath: capture in IDLE, one stage per SHIFT edge, hold in DONE.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         work    <= '0;
         shamt_q <= '0;
         fill_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work    <= in_data;
                  shamt_q <= in_shamt;
                  fill_q  <= in_arith & in_data[WIDTH-1];
                  cnt     <= 3'd0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               work <= stage_out;
               cnt  <= cnt + 3'd1;
               if (cnt == LAST_STAGE) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // Returning to IDLE here means a new request waits one more edge.
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_right_shifter.md
SEQ_RIGHT_SHIFTER -- requirements
Module: seq_right_shifter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state updates SHALL occur on the rising edge of clock.
REQ-002 Parameter WIDTH, default 32: data width in bits; only 32 is supported.
REQ-003 Parameter SHAMT_W, default 5: shift-amount width, equal to log2(WIDTH).
REQ-004 Port clock  input  1  rising-edge clock.
REQ-005 Port reset_n  input  1  synchronous active-low reset.
REQ-006 Port in_valid  input  1  the request fields below are valid.
REQ-007 Port in_ready  output  1  block can accept a request.
REQ-008 Port in_data  input  32  operand to shift.
REQ-009 Port in_shamt  input  5  right-shift amount, 0..31.
REQ-010 Port in_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
REQ-011 Port out_valid  output  1  out_data holds a completed result.
REQ-012 Port out_ready  input  1  consumer accepts the result.
REQ-013 Port out_data  output  32  shifted result.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL equal 1 only in IDLE, decoded combinationally from the state.
REQ-016 On an edge where the state is IDLE and in_valid=1, the block SHALL latch in_data, in_shamt and in_arith, capture fill = in_arith AND in_data[31], clear the 3-bit stage counter and enter SHIFT.
REQ-017 In SHIFT, stage k (0..4) SHALL shift the working register right by 16>>k when shamt[4-k]=1, filling the vacated MSBs with the captured fill bit; otherwise the register is unchanged.
REQ-018 On the edge that applies stage 4, the block SHALL enter DONE, and out_valid SHALL go to 1.
REQ-019 Latency SHALL be fixed, independent of shamt: out_valid rises on the 5th edge after the accepting edge.
REQ-020 In DONE, out_data and out_valid SHALL hold steady until an edge with out_ready=1; on that edge the block SHALL return to IDLE with out_valid=0.
REQ-021 The block SHALL NOT accept a new request on the same edge that a result is consumed; the minimum request interval is 7 cycles.
REQ-022 in_valid SHALL be ignored outside IDLE, and the latched operands SHALL NOT change in that case.
REQ-023 shamt=0 SHALL return in_data unchanged after the full latency.
REQ-024 In an arithmetic shift of a negative operand, every result bit at position 31-n and above SHALL be 1, where n is the shift amount.
REQ-025 out_data SHALL be driven directly from the working register; it is don't-care while out_valid=0.

Reset
REQ-026 When reset_n=0 at an edge, the block SHALL go to IDLE, set out_valid=0, and clear out_data, the stage counter and the latched operands to 0.
REQ-027 After reset, in_ready SHALL be 1 on the following cycle.
REQ-028 Reset asserted during SHIFT or DONE SHALL abort the operation with no result emitted.
REQ-029 Reset SHALL take priority over all handshakes on the same edge.

Structure
REQ-030 A shared package shift_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), WIDTH=32, SHAMT_W=5 and NUM_STAGES=5.
REQ-031 One combinational sub-module, right_shift_stage, SHALL be instantiated once.
REQ-032 right_shift_stage SHALL take (data, stage index, enable, fill) and return data shifted right by 16>>stage when enable=1, else data unchanged.

Verification
REQ-033 Logical, 0x80000000, shamt 31 -> out_data 0x00000001, out_valid on the 5th edge after accept.
REQ-034 Arithmetic, 0x80000000, shamt 4 -> 0xF8000000; arithmetic, 0x7FFFFFF0, shamt 4 -> 0x07FFFFFF.
REQ-035 Logical, 0xDEADBEEF, shamt 0 -> 0xDEADBEEF with the same 5-edge latency.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_data and out_valid stable and in_ready=0; a new in_valid pulse in that window is ignored, then out_ready=1 -> IDLE next edge.
REQ-037 reset_n=0 during the 3rd SHIFT cycle -> next cycle out_valid=0, in_ready=1, out_data=0; a following request completes correctly.
REQ-038 Back-to-back requests with out_ready tied to 1 -> accepts spaced exactly 7 cycles, each result correct.
